// File: rtl/inst_fetch_server_pkg.sv
// Shared types and helpers for the instruction fetch server.
// Contents: FSM state enum, error code constants, instruction width and a
// byte-address to word-index helper.
package inst_fetch_server_pkg;

  localparam int INST_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ALIGN    = 3'd1;
  localparam logic [2:0] ERR_RANGE    = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_SPURIOUS = 3'd4;

  // Byte address to ROM word index.
  function automatic logic [31:0] word_idx(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/inst_fetch_server_if.sv
// Fetch handshake between the instruction server and the processor core.
// master (server): drives in_valid/inst, receives out_valid/inst_addr.
// slave  (core)  : receives in_valid/inst, drives out_valid/inst_addr.
interface inst_fetch_server_if;
  import inst_fetch_server_pkg::*;

  logic              in_valid;
  logic [INST_W-1:0] inst;
  logic              out_valid;
  logic [31:0]       inst_addr;

  modport master (output in_valid, inst, input out_valid, inst_addr);
  modport slave  (input in_valid, inst, output out_valid, inst_addr);

endinterface

// File: rtl/inst_fetch_server_rom.sv
// Program image storage: DEPTH x INST_W words, synchronous write, asynchronous
// read, contents are not reset.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
module inst_fetch_server_rom
  import inst_fetch_server_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_server.sv
// Instruction supply side of the processor fetch handshake. Issues one
// instruction per in_valid pulse, waits for the core to retire it and report
// the next PC, then fetches from that PC after IDLE_GAP idle cycles.
// Ports: clk, rst_n (sync, active low), start, load_en/load_addr/load_data
// (ROM loader, IDLE only), fetch (handshake, master side), busy, done, err,
// err_code, issued_cnt.
//
// state   | meaning
// IDLE    | ROM loading allowed, waiting for start
// GAP     | idle cycles before the next issue
// ISSUE   | in_valid high for exactly this cycle
// WAIT    | waiting for out_valid from the core, latency timer running
// DONE    | INST_LIMIT instructions retired (terminal)
// ERR     | protocol error recorded (terminal)
module inst_fetch_server
  import inst_fetch_server_pkg::*;
#(
  parameter  int DEPTH      = 1024,
  parameter  int IDLE_GAP   = 1,
  parameter  int MAX_LAT    = 10,   // must be >= 3
  parameter  int INST_LIMIT = 325,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      load_en,
  input  logic [AW-1:0]             load_addr,
  input  logic [INST_W-1:0]         load_data,
  inst_fetch_server_if.master       fetch,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [2:0]                err_code,
  output logic [15:0]               issued_cnt
);

  state_t            state;
  logic [AW-1:0]     pc;
  logic [15:0]       gap_cnt;
  logic [15:0]       lat_cnt;
  logic [AW-1:0]     rd_idx;
  logic [INST_W-1:0] rd_data;
  logic [AW-1:0]     addr_idx;
  logic              addr_misaligned;
  logic              addr_oor;
  logic              limit_hit;
  logic [15:0]       cnt_inc;

  assign addr_idx        = fetch.inst_addr[AW+1:2];
  assign addr_misaligned = fetch.inst_addr[1:0] != 2'b00;
  assign addr_oor        = word_idx(fetch.inst_addr) >= 32'(DEPTH);
  assign limit_hit       = issued_cnt == 16'(INST_LIMIT);
  assign cnt_inc         = (issued_cnt == 16'hFFFF) ? issued_cnt : issued_cnt + 16'd1;

  // With IDLE_GAP=0 the issue happens straight out of IDLE/WAIT, so the ROM
  // must be addressed by the PC that is being loaded on that same edge.
  always_comb begin
    rd_idx = pc;
    if (state == S_WAIT)      rd_idx = addr_idx;
    else if (state == S_IDLE) rd_idx = '0;
  end

  inst_fetch_server_rom #(.DEPTH(DEPTH)) u_rom (
    .clk   (clk),
    .we    (state == S_IDLE && load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= '0;
      gap_cnt        <= '0;
      lat_cnt        <= '0;
      fetch.in_valid <= 1'b0;
      fetch.inst     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      err_code       <= ERR_NONE;
      issued_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !load_en) begin
            pc   <= '0;
            busy <= 1'b1;
            if (IDLE_GAP == 0) begin
              state          <= S_ISSUE;
              fetch.in_valid <= 1'b1;
              fetch.inst     <= rd_data;
              issued_cnt     <= cnt_inc;
            end else begin
              gap_cnt <= 16'(IDLE_GAP);
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (fetch.out_valid) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= ERR_SPURIOUS;
            busy     <= 1'b0;
          end else if (gap_cnt == 16'd1) begin
            state          <= S_ISSUE;
            fetch.in_valid <= 1'b1;
            fetch.inst     <= rd_data;
            issued_cnt     <= cnt_inc;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        S_ISSUE: begin
          fetch.in_valid <= 1'b0;
          fetch.inst     <= '0;
          if (fetch.out_valid) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= ERR_SPURIOUS;
            busy     <= 1'b0;
          end else begin
            state   <= S_WAIT;
            // MAX_LAT-2 WAIT cycles may accept out_valid; the error shows up
            // MAX_LAT-1 cycles after the in_valid pulse.
            lat_cnt <= 16'(MAX_LAT - 3);
          end
        end
        S_WAIT: begin
          if (fetch.out_valid) begin
            if (limit_hit) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else if (addr_misaligned) begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_ALIGN;
              busy     <= 1'b0;
            end else if (addr_oor) begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_RANGE;
              busy     <= 1'b0;
            end else begin
              pc <= addr_idx;
              if (IDLE_GAP == 0) begin
                state          <= S_ISSUE;
                fetch.in_valid <= 1'b1;
                fetch.inst     <= rd_data;
                issued_cnt     <= cnt_inc;
              end else begin
                gap_cnt <= 16'(IDLE_GAP);
                state   <= S_GAP;
              end
            end
          end else if (lat_cnt == 16'd0) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            busy     <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 16'd1;
          end
        end
        S_DONE, S_ERR: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_server.sv
// Testbench for inst_fetch_server: timestamp-based reference model compared
// against every output on every cycle, directed scenarios with literal
// expectations, then randomized processor behaviour.
module tb_inst_fetch_server;
  import inst_fetch_server_pkg::*;

  localparam int DEPTH      = 64;
  localparam int IDLE_GAP   = 2;
  localparam int MAX_LAT    = 10;
  localparam int INST_LIMIT = 12;
  localparam int AW         = $clog2(DEPTH);

  localparam logic [31:0] W_A = 32'hA0A0_0001;
  localparam logic [31:0] W_B = 32'hB0B0_0002;
  localparam logic [31:0] W_C = 32'hC0C0_0003;
  localparam logic [31:0] W_D = 32'hD0D0_0004;
  localparam logic [31:0] W_E = 32'hE0E0_0005;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic          busy, done, err;
  logic [2:0]    err_code;
  logic [15:0]   issued_cnt;

  inst_fetch_server_if fetch ();

  inst_fetch_server #(
    .DEPTH(DEPTH), .IDLE_GAP(IDLE_GAP), .MAX_LAT(MAX_LAT), .INST_LIMIT(INST_LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .fetch      (fetch),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Reference model: tracks the cycle of the last issue and the cycle the
  // next issue is due, and derives every output from those timestamps.
  logic [31:0] rom_m [DEPTH];
  bit          running = 0, waiting = 0, m_done = 0, m_err = 0;
  logic [2:0]  m_code = 3'd0;
  logic [15:0] m_cnt = 16'd0;
  logic [31:0] m_pc = 32'd0;
  int          cyc = 0, issue_at = -1, last_issue = -100, prev;
  logic        e_in_valid = 1'b0;
  logic [31:0] e_inst = 32'd0;

  task automatic m_fail(input logic [2:0] c);
    m_err   = 1'b1;
    m_code  = c;
    running = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    prev = cyc - 1;
    e_in_valid = 1'b0;
    e_inst = 32'd0;
    if (!rst_n) begin
      running = 0; waiting = 0; m_done = 0; m_err = 0; m_code = 3'd0;
      m_cnt = 16'd0; m_pc = 32'd0; issue_at = -1; last_issue = -100;
    end else begin
      if (running) begin
        if (fetch.out_valid) begin
          if (waiting && prev > last_issue) begin
            if (m_cnt == 16'(INST_LIMIT)) begin
              m_done = 1'b1;
              running = 1'b0;
            end else if (fetch.inst_addr[1:0] != 2'b00) m_fail(3'd1);
            else if ((fetch.inst_addr >> 2) >= 32'(DEPTH)) m_fail(3'd2);
            else begin
              m_pc = fetch.inst_addr;
              waiting = 1'b0;
              issue_at = prev + 1 + IDLE_GAP;
            end
          end else m_fail(3'd4);
        end else if (waiting && (prev - last_issue) == MAX_LAT - 2) m_fail(3'd3);
      end else if (!m_done && !m_err) begin
        if (load_en) rom_m[load_addr] = load_data;
        else if (start) begin
          running = 1'b1;
          waiting = 1'b0;
          m_pc = 32'd0;
          issue_at = prev + 1 + IDLE_GAP;
        end
      end
      if (running && !waiting && cyc == issue_at) begin
        e_in_valid = 1'b1;
        e_inst = rom_m[m_pc[AW+1:2]];
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        last_issue = cyc;
        waiting = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_valid", 32'(fetch.in_valid), 32'(e_in_valid));
      chk("inst", fetch.inst, e_inst);
      chk("busy", 32'(busy), 32'(running));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("err_code", 32'(err_code), 32'(m_code));
      chk("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; load_en = 1'b0; fetch.out_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    load_en = 1'b1; load_addr = AW'(a); load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    while (fetch.in_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (fetch.in_valid !== 1'b1) chk("issue_wait", 32'(fetch.in_valid), 32'd1);
  endtask

  task automatic reply(input int d, input logic [31:0] a);
    repeat (d) tick();
    fetch.out_valid = 1'b1;
    fetch.inst_addr = a;
    tick();
    fetch.out_valid = 1'b0;
  endtask

  initial begin
    int n, r;
    logic [31:0] a;
    fetch.out_valid = 1'b0;
    fetch.inst_addr = 32'd0;
    do_reset();
    chk_en = 1'b1;
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_cnt0", 32'(issued_cnt), 32'd0);
    for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
    load_word(0, W_A); load_word(1, W_B); load_word(2, W_C);
    load_word(3, W_D); load_word(4, W_E);

    // sequential run, late-but-legal reply, branch, then timeout
    do_start();
    wait_issue(n); chk("gap_start", n, 2); chk("inst_a", fetch.inst, W_A);
    reply(3, 32'h4);
    wait_issue(n); chk("gap_reply", n, 2); chk("inst_b", fetch.inst, W_B);
    reply(3, 32'h8);
    wait_issue(n); chk("inst_c", fetch.inst, W_C);
    reply(3, 32'hC);
    wait_issue(n); chk("inst_d", fetch.inst, W_D); chk("cnt4", 32'(issued_cnt), 32'd4);
    reply(MAX_LAT - 2, 32'h10);
    chk("late_ok", 32'(err), 32'd0);
    wait_issue(n); chk("branch_e", fetch.inst, W_E);
    reply(2, 32'h0);
    wait_issue(n); chk("branch_a", fetch.inst, W_A);
    repeat (MAX_LAT - 2) tick();
    chk("to_early", 32'(err), 32'd0);
    tick();
    chk("to_err", 32'(err), 32'd1);
    chk("to_code", 32'(err_code), 32'd3);

    // address errors and spurious out_valid
    do_reset(); do_start(); wait_issue(n);
    reply(2, 32'h6);
    chk("align_code", 32'(err_code), 32'd1);
    reply(1, 32'h8);
    chk("code_sticky", 32'(err_code), 32'd1);
    do_reset(); do_start(); wait_issue(n);
    reply(2, 32'(DEPTH * 4));
    chk("range_code", 32'(err_code), 32'd2);
    do_reset(); do_start();
    fetch.out_valid = 1'b1; tick(); fetch.out_valid = 1'b0;
    chk("gap_spur_code", 32'(err_code), 32'd4);

    // instruction limit
    do_reset(); do_start();
    for (int k = 0; k < INST_LIMIT; k++) begin
      wait_issue(n);
      reply(1, 32'(4 * (k + 1)));
    end
    chk("done_set", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_cnt", 32'(issued_cnt), 32'(INST_LIMIT));
    do_start();
    repeat (5) tick();
    chk("done_no_issue", 32'(fetch.in_valid), 32'd0);

    // reset mid-wait, then load+start together
    do_reset(); do_start(); wait_issue(n);
    tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(issued_cnt), 32'd0);
    load_en = 1'b1; start = 1'b1; load_addr = AW'(5); load_data = 32'h5A5A_0005;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick();
    chk("ls_idle", 32'(busy), 32'd0);
    do_start(); wait_issue(n);
    chk("rom_kept", fetch.inst, W_A);
    reply(1, 32'h14);
    wait_issue(n);
    chk("ls_write", fetch.inst, 32'h5A5A_0005);

    // randomized processor behaviour
    for (int ep = 0; ep < 60; ep++) begin
      do_reset();
      repeat ($urandom_range(0, 3)) begin
        load_en = 1'b1;
        load_addr = AW'($urandom_range(0, DEPTH - 1));
        load_data = $urandom;
        start = 1'($urandom_range(0, 1));
        tick();
        load_en = 1'b0; start = 1'b0;
      end
      do_start();
      while (running) begin
        wait_issue(n);
        if (fetch.in_valid !== 1'b1) break;
        r = $urandom_range(0, 99);
        if (r < 72) begin
          a = 32'(4 * $urandom_range(0, DEPTH - 1));
          reply($urandom_range(1, MAX_LAT - 2), a);
        end else if (r < 78) begin
          a = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
          reply($urandom_range(1, MAX_LAT - 2), a);
        end else if (r < 84) begin
          a = 32'(DEPTH * 4 + 4 * $urandom_range(0, 1000));
          reply($urandom_range(1, MAX_LAT - 2), a);
        end else if (r < 90) begin
          repeat (MAX_LAT + 1) tick();
        end else if (r < 95) begin
          reply(0, 32'h0);
        end else begin
          repeat ($urandom_range(1, 6)) tick();
          rst_n = 1'b0; tick(); rst_n = 1'b1;
        end
      end
      repeat (3) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
